// File: rtl/spi_tx_arbiter_if.sv
// Request/serializer bundle shared between spi_tx_arbiter and its clients.
// master = arbiter side, slave = requesters plus frame serializer.
interface spi_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         req_ready;
    logic [$clog2(NUM_REQ)-1:0] owner;
    logic                       xfer_start;
    logic [DATA_W-1:0]          xfer_data;
    logic                       xfer_done;
    logic                       busy;
    logic                       err_timeout;
    logic [15:0]                frame_count;

    modport master (
        input  req_valid, req_data, xfer_done,
        output req_ready, owner, xfer_start, xfer_data, busy, err_timeout, frame_count
    );

    modport slave (
        output req_valid, req_data, xfer_done,
        input  req_ready, owner, xfer_start, xfer_data, busy, err_timeout, frame_count
    );
endinterface

// File: rtl/spi_tx_arbiter.sv
// Round-robin sharing of one SPI frame serializer among NUM_REQ requesters,
// with frame-done watchdog and a fixed inter-frame gap. All outputs registered.
module spi_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 16,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    spi_tx_arbiter_if.master bus
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

    state_t              state, state_n;
    logic [CW-1:0]       wd_cnt, wd_cnt_n;
    logic [GW-1:0]       gap_cnt, gap_cnt_n;
    logic [OW-1:0]       last_grant, last_grant_n;
    logic [OW-1:0]       owner_r, owner_n;
    logic [DATA_W-1:0]   data_r, data_n;
    logic [NUM_REQ-1:0]  ready_r, ready_n;
    logic                start_r, start_n;
    logic                err_r, err_n;
    logic                busy_r, busy_n;
    logic [15:0]         fc_r, fc_n;

    logic [DATA_W-1:0]   words [NUM_REQ];
    logic [OW-1:0]       winner;
    logic                found;
    logic [OW:0]         scan;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
        assign words[g] = bus.req_data[g*DATA_W +: DATA_W];
    end

    // Scan starts one past the last grant and wraps, so the most recent owner is served last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        scan   = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            scan = {1'b0, last_grant} + (OW+1)'(off);
            if (scan >= (OW+1)'(NUM_REQ)) begin
                scan = scan - (OW+1)'(NUM_REQ);
            end
            if (!found && bus.req_valid[scan[OW-1:0]]) begin
                found  = 1'b1;
                winner = scan[OW-1:0];
            end
        end
    end

    always_comb begin
        state_n      = state;
        wd_cnt_n     = wd_cnt;
        gap_cnt_n    = gap_cnt;
        last_grant_n = last_grant;
        owner_n      = owner_r;
        data_n       = data_r;
        fc_n         = fc_r;
        ready_n      = '0;
        start_n      = 1'b0;
        err_n        = 1'b0;

        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n = START;
                    owner_n = winner;
                    data_n  = words[winner];
                    ready_n = NUM_REQ'(1) << winner;
                    start_n = 1'b1;
                end
            end
            START: begin
                state_n  = WAIT;
                wd_cnt_n = '0;
            end
            WAIT: begin
                // Done is tested first so a done on the final watchdog cycle still completes.
                if (bus.xfer_done) begin
                    fc_n         = fc_r + 16'd1;
                    last_grant_n = owner_r;
                    state_n      = (GAP_CYCLES == 0) ? IDLE : GAP;
                    gap_cnt_n    = '0;
                end else if (wd_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    err_n        = 1'b1;
                    last_grant_n = owner_r;
                    state_n      = (GAP_CYCLES == 0) ? IDLE : GAP;
                    gap_cnt_n    = '0;
                end else begin
                    wd_cnt_n = wd_cnt + CW'(1);
                end
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    state_n = IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + GW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wd_cnt     <= '0;
            gap_cnt    <= '0;
            last_grant <= OW'(NUM_REQ - 1);
            owner_r    <= '0;
            data_r     <= '0;
            ready_r    <= '0;
            start_r    <= 1'b0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
            fc_r       <= '0;
        end else begin
            state      <= state_n;
            wd_cnt     <= wd_cnt_n;
            gap_cnt    <= gap_cnt_n;
            last_grant <= last_grant_n;
            owner_r    <= owner_n;
            data_r     <= data_n;
            ready_r    <= ready_n;
            start_r    <= start_n;
            err_r      <= err_n;
            busy_r     <= busy_n;
            fc_r       <= fc_n;
        end
    end

    assign bus.req_ready   = ready_r;
    assign bus.owner       = owner_r;
    assign bus.xfer_start  = start_r;
    assign bus.xfer_data   = data_r;
    assign bus.busy        = busy_r;
    assign bus.err_timeout = err_r;
    assign bus.frame_count = fc_r;
endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Scoreboard bench for spi_tx_arbiter: requester agents with word queues, a
// serializer stub with scripted done delays, and a transaction-level grant model.
module tb_spi_tx_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 16;
    localparam int GAP     = 2;
    localparam int TO      = 64;
    localparam int MAXW    = 8;

    typedef struct {
        int                owner;
        logic [DATA_W-1:0] data;
        bit                timeout;
    } exp_t;

    typedef struct {
        int delay;
        bit spur_start;
        bit spur_gap;
    } stub_t;

    logic clk        = 1'b0;
    logic rst        = 1'b1;
    logic stub_done  = 1'b0;
    logic idle_pulse = 1'b0;

    int checks   = 0;
    int failures = 0;

    exp_t  exp_q[$];
    stub_t stub_q[$];
    exp_t  mon_cur;
    bit    mon_open = 1'b0;

    logic [DATA_W-1:0] wbuf [NUM_REQ][MAXW];
    int wcnt [NUM_REQ];
    int wrd  [NUM_REQ];
    int m_last = NUM_REQ - 1;
    int m_fc   = 0;

    always #5 clk = ~clk;

    spi_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();
    assign bus.xfer_done = stub_done | idle_pulse;

    spi_tx_arbiter #(
        .NUM_REQ(NUM_REQ),
        .DATA_W(DATA_W),
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic bit pending();
        for (int i = 0; i < NUM_REQ; i++) if (wrd[i] < wcnt[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_valid[i] = (wrd[i] < wcnt[i]);
            bus.req_data[i*DATA_W +: DATA_W] = (wrd[i] < wcnt[i]) ? wbuf[i][wrd[i]] : DATA_W'($urandom);
        end
    endtask

    // Requester agents: on an observed ready, advance to the next word or drop valid.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_ready[i] && wrd[i] < wcnt[i]) wrd[i]++;
            end
        end
        drive_reqs();
    endtask

    task automatic clear_words();
        for (int i = 0; i < NUM_REQ; i++) begin
            wcnt[i] = 0;
            wrd[i]  = 0;
        end
    endtask

    task automatic add_word(input int i, input logic [DATA_W-1:0] d);
        wbuf[i][wcnt[i]] = d;
        wcnt[i]++;
    endtask

    function automatic int rand_delay();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0:       return 0;
            1:       return TO;
            2:       return TO + 1;
            default: return $urandom_range(1, 40);
        endcase
    endfunction

    // Grant order model: rotate from the last owner over requesters that still hold words.
    task automatic plan(input int fixed_d, input bit spur);
        int    rem [NUM_REQ];
        int    left;
        int    c;
        exp_t  e;
        stub_t s;
        left = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rem[i] = wcnt[i] - wrd[i];
            left  += rem[i];
        end
        while (left > 0) begin
            c = 0;
            for (int off = 1; off <= NUM_REQ; off++) begin
                c = (m_last + off) % NUM_REQ;
                if (rem[c] > 0) break;
            end
            e.owner = c;
            e.data  = wbuf[c][wcnt[c] - rem[c]];
            rem[c]--;
            left--;
            if (fixed_d >= 0) begin
                s.delay      = fixed_d;
                s.spur_start = spur;
                s.spur_gap   = spur;
            end else begin
                s.delay      = rand_delay();
                s.spur_start = ($urandom_range(0, 3) == 0);
                s.spur_gap   = ($urandom_range(0, 3) == 0);
            end
            e.timeout = (s.delay == 0) || (s.delay > TO);
            if (!e.timeout) m_fc++;
            exp_q.push_back(e);
            stub_q.push_back(s);
            m_last = c;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((pending() || bus.busy || exp_q.size() != 0) && n < 20000) begin
            tick();
            n++;
        end
        chk("drain_bound", 64'(n < 20000), 1);
        chk("frame_count", bus.frame_count, 64'(m_fc));
    endtask

    task automatic run_burst(input int fixed_d, input bit spur);
        plan(fixed_d, spur);
        drive_reqs();
        wait_drain();
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!bus.xfer_start && n < 100) begin
            tick();
            n++;
        end
        chk("start_seen", bus.xfer_start, 1);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_req_ready"},   bus.req_ready,   0);
        chk({tag, "_xfer_start"},  bus.xfer_start,  0);
        chk({tag, "_xfer_data"},   bus.xfer_data,   0);
        chk({tag, "_owner"},       bus.owner,       0);
        chk({tag, "_err_timeout"}, bus.err_timeout, 0);
        chk({tag, "_frame_count"}, bus.frame_count, 0);
        chk({tag, "_busy"},        bus.busy,        0);
    endtask

    // Serializer stub: done after the scripted delay, optional stray pulses in START and GAP.
    initial begin
        int    cnt;
        bit    armed;
        bit    gap_p;
        stub_t s;
        cnt   = 0;
        armed = 1'b0;
        gap_p = 1'b0;
        s.delay = 0; s.spur_start = 1'b0; s.spur_gap = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            stub_done = 1'b0;
            if (rst) begin
                armed = 1'b0;
                gap_p = 1'b0;
            end else begin
                if (gap_p) begin
                    stub_done = 1'b1;
                    gap_p     = 1'b0;
                end
                if (armed) begin
                    if (cnt == 1) begin
                        stub_done = 1'b1;
                        armed     = 1'b0;
                        gap_p     = s.spur_gap;
                    end else begin
                        cnt--;
                    end
                end
                if (bus.xfer_start) begin
                    if (stub_q.size() > 0) begin
                        s = stub_q.pop_front();
                    end else begin
                        s.delay = 0; s.spur_start = 1'b0; s.spur_gap = 1'b0;
                    end
                    if (s.spur_start) stub_done = 1'b1;
                    armed = (s.delay > 0);
                    cnt   = s.delay;
                end
            end
        end
    end

    // Monitor: compares each start/ready and each frame outcome against the expected queue.
    initial begin
        logic [15:0] prev_fc;
        logic [15:0] exp_fc;
        prev_fc = '0;
        exp_fc  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_open = 1'b0;
                prev_fc  = bus.frame_count;
                exp_fc   = '0;
            end else begin
                if (bus.xfer_start) begin
                    chk("stale_outcome", 64'(mon_open), 0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_start", 64'(exp_q.size()), 1);
                    end else begin
                        mon_cur  = exp_q.pop_front();
                        mon_open = 1'b1;
                        chk("owner",     bus.owner,     64'(mon_cur.owner));
                        chk("xfer_data", bus.xfer_data, mon_cur.data);
                        chk("req_ready", bus.req_ready, 64'(1) << mon_cur.owner);
                    end
                end else if (bus.req_ready != '0) begin
                    chk("stray_ready", bus.req_ready, 0);
                end
                if (bus.busy && mon_open) begin
                    chk("data_stable", bus.xfer_data, mon_cur.data);
                end
                if (bus.err_timeout) begin
                    chk("timeout_expected", 64'(mon_open && mon_cur.timeout), 1);
                    mon_open = 1'b0;
                end
                if (bus.frame_count != prev_fc) begin
                    chk("done_expected", 64'(mon_open && !mon_cur.timeout), 1);
                    exp_fc = exp_fc + 16'd1;
                    chk("frame_count_step", bus.frame_count, exp_fc);
                    mon_open = 1'b0;
                    prev_fc  = bus.frame_count;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        int mask;
        clear_words();
        drive_reqs();
        rst = 1'b1;
        repeat (3) tick();
        check_cleared("reset");
        rst = 1'b0;
        tick();

        // Single requester, done 34 cycles after start.
        add_word(0, 16'hA569);
        plan(34, 1'b0);
        drive_reqs();
        wait_start(n);
        chk("start_latency", 64'(n), 1);
        n = 0;
        while (bus.busy && n < 200) begin
            tick();
            n++;
        end
        chk("busy_drop_latency", 64'(n), 64'(34 + GAP + 1));
        wait_drain();

        // Everyone valid, requester 0 stays valid for a second frame.
        clear_words();
        add_word(0, 16'h2563);
        add_word(0, 16'h2563);
        add_word(1, 16'h9B63);
        add_word(2, 16'h6A61);
        add_word(3, 16'hA265);
        run_burst(5, 1'b0);

        // Watchdog abort, then the rotation continues past the aborted owner.
        clear_words();
        add_word(1, 16'h1234);
        plan(0, 1'b0);
        drive_reqs();
        wait_start(n);
        n = 0;
        while (!bus.err_timeout && n < 200) begin
            tick();
            n++;
        end
        chk("timeout_latency", 64'(n), 64'(TO + 1));
        wait_drain();
        clear_words();
        for (int i = 0; i < NUM_REQ; i++) add_word(i, DATA_W'($urandom));
        run_burst(3, 1'b0);

        // Reset while requester 2 owns a frame in WAIT.
        clear_words();
        add_word(2, 16'hC0DE);
        plan(0, 1'b0);
        drive_reqs();
        wait_start(n);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        check_cleared("rst_wait");
        clear_words();
        exp_q.delete();
        stub_q.delete();
        m_last = NUM_REQ - 1;
        m_fc   = 0;
        tick();
        rst = 1'b0;
        add_word(0, 16'h0F0F);
        add_word(2, 16'hF0F0);
        run_burst(4, 1'b0);

        // Stray done pulses in IDLE, START and GAP.
        @(negedge clk);
        idle_pulse = 1'b1;
        @(negedge clk);
        idle_pulse = 1'b0;
        repeat (3) tick();
        chk("spur_idle_fc",   bus.frame_count, 64'(m_fc));
        chk("spur_idle_busy", bus.busy, 0);
        clear_words();
        add_word(1, 16'h5A5A);
        add_word(3, 16'hA5A5);
        run_burst(6, 1'b1);

        // Randomized bursts.
        for (int it = 0; it < 30; it++) begin
            clear_words();
            mask = $urandom_range(1, (1 << NUM_REQ) - 1);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (((mask >> i) & 1) != 0) begin
                    n = $urandom_range(1, 3);
                    for (int k = 0; k < n; k++) add_word(i, DATA_W'($urandom));
                end
            end
            run_burst(-1, 1'b0);
        end

        repeat (4) tick();
        chk("exp_queue_empty", 64'(exp_q.size()), 0);
        chk("outcome_pending", 64'(mon_open), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
